// File: rtl/issue_queue_8.sv
// 8-entry out-of-order issue queue (reservation station).
// Tracks operand readiness by tag wakeup and issues the granted entry.
module issue_queue_8 #(
  parameter int RRF_SEL = 6,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [RRF_SEL-1:0]         disp_age,
  input  logic [RRF_SEL-1:0]         disp_src1_tag,
  input  logic [RRF_SEL-1:0]         disp_src2_tag,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic                       wk_valid0,
  input  logic                       wk_valid1,
  input  logic [RRF_SEL-1:0]         wk_tag0,
  input  logic [RRF_SEL-1:0]         wk_tag1,
  output logic [DEPTH-1:0]           req,
  output logic [DEPTH*RRF_SEL-1:0]   age_flat,
  output logic [DEPTH*3-1:0]         index_flat,
  input  logic                       sel_grant,
  input  logic [2:0]                 sel_index,
  output logic                       issue_valid,
  output logic [RRF_SEL-1:0]         issue_age,
  output logic [RRF_SEL-1:0]         issue_src1_tag,
  output logic [RRF_SEL-1:0]         issue_src2_tag,
  output logic                       issue_err
);

  typedef logic [RRF_SEL-1:0] tag_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] s1rdy_q, s1rdy_d;
  logic [DEPTH-1:0] s2rdy_q, s2rdy_d;
  tag_t             age_q  [DEPTH];
  tag_t             age_d  [DEPTH];
  tag_t             s1tag_q[DEPTH];
  tag_t             s1tag_d[DEPTH];
  tag_t             s2tag_q[DEPTH];
  tag_t             s2tag_d[DEPTH];

  logic             iss_valid_q, iss_valid_d;
  logic             iss_err_q, iss_err_d;
  tag_t             iss_age_q, iss_age_d;
  tag_t             iss_s1_q, iss_s1_d;
  tag_t             iss_s2_q, iss_s2_d;

  logic [2:0]       alloc_idx;
  logic             disp_fire;
  logic             grant_ok;
  logic             grant_bad;

  function automatic logic wake(input tag_t t);
    return (wk_valid0 && (wk_tag0 == t)) ||
           (wk_valid1 && (wk_tag1 == t));
  endfunction

  assign req        = valid_q & s1rdy_q & s2rdy_q;
  assign disp_ready = ~&valid_q;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign grant_ok   = sel_grant & req[sel_index] & ~flush;
  assign grant_bad  = sel_grant & ~req[sel_index] & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign age_flat[g*RRF_SEL +: RRF_SEL] = age_q[g];
    assign index_flat[g*3 +: 3]           = 3'(g);
  end

  // Lowest-index free slot, judged on the pre-edge valid vector
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = 3'(i);
    end
  end

  // Entry next state: wakeup, grant release, dispatch write, flush
  always_comb begin
    valid_d = valid_q;
    s1rdy_d = s1rdy_q;
    s2rdy_d = s2rdy_q;
    age_d   = age_q;
    s1tag_d = s1tag_q;
    s2tag_d = s2tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (wake(s1tag_q[i])) s1rdy_d[i] = 1'b1;
        if (wake(s2tag_q[i])) s2rdy_d[i] = 1'b1;
      end
    end
    if (grant_ok) valid_d[sel_index] = 1'b0;
    if (disp_fire) begin
      valid_d[alloc_idx] = 1'b1;
      age_d[alloc_idx]   = disp_age;
      s1tag_d[alloc_idx] = disp_src1_tag;
      s2tag_d[alloc_idx] = disp_src2_tag;
      s1rdy_d[alloc_idx] = disp_src1_rdy | wake(disp_src1_tag);
      s2rdy_d[alloc_idx] = disp_src2_rdy | wake(disp_src2_tag);
    end
    if (flush) valid_d = '0;
  end

  // Issue register next state; payload holds when nothing issues
  always_comb begin
    iss_valid_d = grant_ok;
    iss_err_d   = grant_bad;
    iss_age_d   = iss_age_q;
    iss_s1_d    = iss_s1_q;
    iss_s2_d    = iss_s2_q;
    if (grant_ok) begin
      iss_age_d = age_q[sel_index];
      iss_s1_d  = s1tag_q[sel_index];
      iss_s2_d  = s2tag_q[sel_index];
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      s1rdy_q <= '0;
      s2rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]   <= '0;
        s1tag_q[i] <= '0;
        s2tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      s1rdy_q <= s1rdy_d;
      s2rdy_q <= s2rdy_d;
      age_q   <= age_d;
      s1tag_q <= s1tag_d;
      s2tag_q <= s2tag_d;
    end
  end

  // Issue output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_err_q   <= 1'b0;
      iss_age_q   <= '0;
      iss_s1_q    <= '0;
      iss_s2_q    <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_err_q   <= iss_err_d;
      iss_age_q   <= iss_age_d;
      iss_s1_q    <= iss_s1_d;
      iss_s2_q    <= iss_s2_d;
    end
  end

  assign issue_valid    = iss_valid_q;
  assign issue_err      = iss_err_q;
  assign issue_age      = iss_age_q;
  assign issue_src1_tag = iss_s1_q;
  assign issue_src2_tag = iss_s2_q;

endmodule

// File: tb/tb_issue_queue_8.sv
// Self-checking bench for issue_queue_8.
// Expected issues are queued at grant time and matched on output.
module tb_issue_queue_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_age;
  logic [5:0]  disp_src1_tag;
  logic [5:0]  disp_src2_tag;
  logic        disp_src1_rdy;
  logic        disp_src2_rdy;
  logic        wk_valid0;
  logic        wk_valid1;
  logic [5:0]  wk_tag0;
  logic [5:0]  wk_tag1;
  logic [7:0]  req;
  logic [47:0] age_flat;
  logic [23:0] index_flat;
  logic        sel_grant;
  logic [2:0]  sel_index;
  logic        issue_valid;
  logic [5:0]  issue_age;
  logic [5:0]  issue_src1_tag;
  logic [5:0]  issue_src2_tag;
  logic        issue_err;

  typedef struct {
    bit         err;
    logic [5:0] age;
    logic [5:0] s1;
    logic [5:0] s2;
  } iss_t;

  iss_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  issue_queue_8 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_age       (disp_age),
    .disp_src1_tag  (disp_src1_tag),
    .disp_src2_tag  (disp_src2_tag),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_rdy  (disp_src2_rdy),
    .wk_valid0      (wk_valid0),
    .wk_valid1      (wk_valid1),
    .wk_tag0        (wk_tag0),
    .wk_tag1        (wk_tag1),
    .req            (req),
    .age_flat       (age_flat),
    .index_flat     (index_flat),
    .sel_grant      (sel_grant),
    .sel_index      (sel_index),
    .issue_valid    (issue_valid),
    .issue_age      (issue_age),
    .issue_src1_tag (issue_src1_tag),
    .issue_src2_tag (issue_src2_tag),
    .issue_err      (issue_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] agei(input int i);
    return age_flat[i*6 +: 6];
  endfunction

  task automatic idle_in();
    flush      = 1'b0;
    disp_valid = 1'b0;
    sel_grant  = 1'b0;
    sel_index  = '0;
    wk_valid0  = 1'b0;
    wk_valid1  = 1'b0;
    wk_tag0    = '0;
    wk_tag1    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle_in();
  endtask

  task automatic disp(input logic [5:0] a,
                      input logic [5:0] t1, input logic r1,
                      input logic [5:0] t2, input logic r2);
    disp_valid    = 1'b1;
    disp_age      = a;
    disp_src1_tag = t1;
    disp_src1_rdy = r1;
    disp_src2_tag = t2;
    disp_src2_rdy = r2;
  endtask

  task automatic grant(input logic [2:0] idx);
    sel_grant = 1'b1;
    sel_index = idx;
  endtask

  task automatic expect_iss(input bit e, input logic [5:0] a,
                            input logic [5:0] s1, input logic [5:0] s2);
    iss_t r;
    r.err = e;
    r.age = a;
    r.s1  = s1;
    r.s2  = s2;
    sb.push_back(r);
  endtask

  // Output monitor: every issue or error pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n && (issue_valid || issue_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", {issue_valid, issue_err}, 2'b00);
      end else begin
        iss_t r;
        r = sb.pop_front();
        chk("iss_valid", issue_valid, !r.err);
        chk("iss_err", issue_err, r.err);
        if (!r.err) begin
          chk("iss_age", issue_age, r.age);
          chk("iss_src1", issue_src1_tag, r.s1);
          chk("iss_src2", issue_src2_tag, r.s2);
        end
      end
    end
  end

  initial begin
    logic [47:0] exp_age;
    logic [23:0] exp_idx;
    rst_n = 1'b0;
    idle_in();
    disp_age      = '0;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_src1_rdy = 1'b0;
    disp_src2_rdy = 1'b0;
    #12;
    chk("rst_req", req, 8'h00);
    chk("rst_rdy", disp_ready, 1'b1);
    chk("rst_ivalid", issue_valid, 1'b0);
    chk("rst_ierr", issue_err, 1'b0);
    chk("rst_iage", issue_age, 6'd0);
    chk("rst_is1", issue_src1_tag, 6'd0);
    chk("rst_is2", issue_src2_tag, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      disp(6'(10 + i), 6'(i), 1'b1, 6'(i + 1), 1'b1);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      exp_age[i*6 +: 6] = 6'(10 + i);
      exp_idx[i*3 +: 3] = 3'(i);
    end
    chk("fill_req", req, 8'hFF);
    chk("fill_rdy", disp_ready, 1'b0);
    chk("fill_age", age_flat, exp_age);
    chk("index_flat", index_flat, exp_idx);

    disp(6'd40, 6'd9, 1'b1, 6'd9, 1'b1);
    step();
    chk("drop9_req", req, 8'hFF);
    chk("drop9_age", age_flat, exp_age);

    disp(6'd50, 6'd9, 1'b1, 6'd9, 1'b1);
    grant(3'd0);
    #1;
    chk("fg_rdy_low", disp_ready, 1'b0);
    expect_iss(1'b0, 6'd10, 6'd0, 6'd1);
    step();
    chk("fg_req", req, 8'hFE);
    chk("fg_rdy", disp_ready, 1'b1);
    chk("fg_age0", agei(0), 6'd10);

    disp(6'd60, 6'd3, 1'b1, 6'd4, 1'b1);
    step();
    chk("refill_age0", agei(0), 6'd60);
    chk("refill_req", req, 8'hFF);

    flush = 1'b1;
    step();
    chk("fl1_req", req, 8'h00);
    chk("fl1_rdy", disp_ready, 1'b1);

    disp(6'd5, 6'd20, 1'b0, 6'd21, 1'b1);
    step();
    chk("wk_pend", req, 8'h00);
    wk_valid0 = 1'b1;
    wk_tag0   = 6'd20;
    #1;
    chk("wk_same_cyc", req, 8'h00);
    step();
    chk("wk_req", req, 8'h01);

    disp(6'd9, 6'd33, 1'b0, 6'd34, 1'b1);
    wk_valid1 = 1'b1;
    wk_tag1   = 6'd33;
    step();
    chk("bypass_req", req, 8'h03);

    disp(6'd11, 6'd40, 1'b0, 6'd41, 1'b0);
    step();
    chk("dual_pend", req, 8'h03);
    wk_valid0 = 1'b1;
    wk_tag0   = 6'd40;
    wk_valid1 = 1'b1;
    wk_tag1   = 6'd41;
    step();
    chk("dual_req", req, 8'h07);

    disp(6'd7, 6'd1, 1'b1, 6'd2, 1'b1);
    step();
    chk("e3_req", req, 8'h0F);
    grant(3'd3);
    expect_iss(1'b0, 6'd7, 6'd1, 6'd2);
    step();
    chk("iss3_req", req, 8'h07);
    step();
    chk("iss_pulse", issue_valid, 1'b0);
    chk("iss_hold", issue_age, 6'd7);

    grant(3'd1);
    disp(6'd12, 6'd5, 1'b1, 6'd6, 1'b1);
    expect_iss(1'b0, 6'd9, 6'd33, 6'd34);
    step();
    chk("gd_req", req, 8'h0D);
    chk("gd_age3", agei(3), 6'd12);

    disp(6'd13, 6'd50, 1'b0, 6'd51, 1'b1);
    step();
    disp(6'd14, 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    chk("five_req", req, 8'h1D);

    grant(3'd1);
    expect_iss(1'b1, 6'd0, 6'd0, 6'd0);
    step();
    chk("bad_req", req, 8'h1D);
    step();
    chk("err_pulse", issue_err, 1'b0);

    flush = 1'b1;
    grant(3'd0);
    disp(6'd15, 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    chk("fl2_req", req, 8'h00);
    chk("fl2_rdy", disp_ready, 1'b1);
    chk("fl2_noiss", issue_valid, 1'b0);
    step();
    chk("fl2_idle", req, 8'h00);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/issue_queue_8.md
Name: issue_queue_8

Overview:
- 8-entry out-of-order issue queue (reservation station). It feeds the oldest-first 1-of-8 select tree: it drives per-entry request, age and index, and consumes the tree's grant and winning index.
- It accepts one dispatched instruction per cycle, tracks source-operand readiness through tag wakeup, and frees the granted entry.
- It issues the granted entry's payload as a registered output.
- Position: between rename/dispatch and the execution unit.

Parameters:
- RRF_SEL, 6, width of rename-register tags and of the age field; a numerically smaller age is older.
- DEPTH, 8, number of entries; fixed at 8 to match the 3-bit select index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; invalidates all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  1 when at least one entry is free (combinational from the valid vector).
- disp_age  in  RRF_SEL  age of the dispatched instruction (its destination RRF tag).
- disp_src1_tag, disp_src2_tag  in  RRF_SEL each  source tags.
- disp_src1_rdy, disp_src2_rdy  in  1 each  source operand already available.
- wk_valid0, wk_valid1  in  1 each  wakeup broadcast valids.
- wk_tag0, wk_tag1  in  RRF_SEL each  wakeup broadcast tags.
- req  out  8  per-entry request to the select tree: valid & src1_rdy & src2_rdy.
- age_flat  out  8*RRF_SEL  entry i age at bits [i*RRF_SEL +: RRF_SEL].
- index_flat  out  24  constant; entry i index = i.
- sel_grant  in  1  grant from the select tree (same cycle as req).
- sel_index  in  3  winning entry index from the select tree.
- issue_valid  out  1  registered issue strobe.
- issue_age, issue_src1_tag, issue_src2_tag  out  RRF_SEL each  registered payload of the issued entry.
- issue_err  out  1  registered; 1-cycle pulse when a grant targets an entry whose req is 0.

Behaviour:
- Reset (rst_n=0, asynchronous): all entry valid bits 0. issue_valid=0, issue_err=0, all issue payload outputs 0. req=0, so disp_ready=1.
- Entry state: valid, age, src1_tag, src1_rdy, src2_tag, src2_rdy. No state machine beyond these per-entry bits.
- Allocation: on disp_valid & disp_ready, write the lowest-index entry that is currently free. "Free" is judged on the valid vector before this edge.
  - A slot released by a grant in the same cycle is not reusable until the next cycle.
  - When full, disp_ready=0 and dispatch is ignored, even if a grant is present that cycle.
- Dispatch bypass: a source is written as ready if its disp_srcN_rdy=1, or if any same-cycle wakeup (wk_validK & wk_tagK==disp_srcN_tag) matches.
- Wakeup: every valid entry whose pending tag equals a valid wakeup tag sets the corresponding rdy bit at the edge.
  - Both broadcasts may match one entry, one per source or the same source; the result is the OR.
  - Wakeup takes effect on req in the cycle after the broadcast.
- Select interface: req is combinational from registered state. age_flat and index_flat are always driven; age of an invalid entry is don't-care but stable.
- Issue, when sel_grant=1 and req[sel_index]=1:
  - At the edge, clear valid[sel_index].
  - Register that entry's age and tags into the issue_* outputs and set issue_valid=1 for one cycle.
  - Issue latency is 1 cycle from grant.
- Invalid grant, when sel_grant=1 and req[sel_index]=0: no state change, issue_valid=0, issue_err=1 for one cycle.
- No grant: issue_valid=0, and payload outputs hold their last values.
- Flush:
  - All valid bits clear at the edge and issue_valid=0 next cycle.
  - Flush has priority over a same-cycle dispatch and grant; both are dropped.
- Simultaneous dispatch and grant to different entries: both take effect.
- Age values are stored verbatim. Wrap-around ordering is the rename stage's responsibility; the queue does not reorder.

Test Plan:
- Reset then fill: dispatch 8 entries with ages 10..17, all sources ready, while holding sel_grant=0 → req=8'hFF, and disp_ready=0 after the 8th. A 9th dispatch is dropped with no state change.
- Wakeup: dispatch age=5, src1_tag=20 not ready, src2 ready → req[0]=0. Apply wk_valid0=1, wk_tag0=20 → req[0]=1 on the next cycle.
- Dispatch bypass: dispatch src1_tag=33 not ready in the same cycle as wk_valid1=1, wk_tag1=33 → entry written ready and req set next cycle.
- Issue: with entry 3 holding age=7 and src tags 1/2, drive sel_grant=1, sel_index=3 → next cycle issue_valid=1, issue_age=7, issue_src1_tag=1, issue_src2_tag=2, and req[3]=0.
- Full plus grant: queue full, grant index 0 together with disp_valid → dispatch dropped that cycle. Next cycle disp_ready=1 and the next dispatch lands in entry 0.
- Bad grant and flush: grant to an entry with req=0 → issue_err=1 pulse, issue_valid=0. Then flush with 5 valid entries and a concurrent grant → req=0, disp_ready=1, no issue.
